// File: rtl/reg_file_wb.sv
// Architectural register file at the tail of write-back: one write port, two read ports with write-first bypass.
// Latency: a write lands in storage on the next rising clk edge; both read ports are combinational (0 cycles).
// Backpressure: none; a write is taken every cycle. Writes to index 15 (PC) or beyond are silently dropped.
module reg_file_wb #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_LEN   = 4,
  parameter int NUM_REGS   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_LEN-1:0]   src1,
  input  logic [ADDR_LEN-1:0]   src2,
  input  logic [ADDR_LEN-1:0]   WB_dst,
  input  logic                  WB_en,
  input  logic [WORD_WIDTH-1:0] WB_value,
  output logic [WORD_WIDTH-1:0] reg1,
  output logic [WORD_WIDTH-1:0] reg2,
  output logic                  byp1,
  output logic                  byp2
);

  // Only R0..R(NUM_REGS-1) exist; the PC slot has no storage here.
  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  logic                  src1_ok;
  logic                  src2_ok;
  logic [WORD_WIDTH-1:0] stored1;
  logic [WORD_WIDTH-1:0] stored2;
  logic                  hit1;
  logic                  hit2;

  // Storage: asynchronous load of each register's own index on reset, otherwise one WB write per edge.
  // The write decode compares against every implemented index, so an out-of-range WB_dst matches nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= WORD_WIDTH'(i);
      end
    end else if (WB_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (WB_dst == ADDR_LEN'(i)) begin
          regs[i] <= WB_value;
        end
      end
    end
  end

  // Read decode: select the stored word for each port; an unimplemented index yields zero and no match.
  always_comb begin
    src1_ok = 1'b0;
    src2_ok = 1'b0;
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (src1 == ADDR_LEN'(i)) begin
        src1_ok = 1'b1;
        stored1 = regs[i];
      end
      if (src2 == ADDR_LEN'(i)) begin
        src2_ok = 1'b1;
        stored2 = regs[i];
      end
    end
  end

  // Bypass qualifies on a valid read index so a WB to the PC slot never forwards,
  // and is masked during reset so reads show the reset contents only.
  assign hit1 = src1_ok && WB_en && !rst && (WB_dst == src1);
  assign hit2 = src2_ok && WB_en && !rst && (WB_dst == src2);

  // Output mux: the in-flight WB value takes priority over storage (write-first).
  always_comb begin
    reg1 = hit1 ? WB_value : stored1;
    reg2 = hit2 ? WB_value : stored2;
    byp1 = hit1;
    byp2 = hit2;
  end

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;
  localparam int W = 32;
  localparam int A = 4;
  localparam int N = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic [A-1:0] src1, src2, WB_dst;
  logic         WB_en;
  logic [W-1:0] WB_value;
  logic [W-1:0] reg1, reg2;
  logic         byp1, byp2;

  int checks = 0;
  int errors = 0;

  // Reference contents of R0..R14 as the architecture sees them.
  logic [W-1:0] model [N];

  always #10 clk = ~clk;

  reg_file_wb #(.WORD_WIDTH(W), .ADDR_LEN(A), .NUM_REGS(N)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2),
    .WB_dst(WB_dst), .WB_en(WB_en), .WB_value(WB_value),
    .reg1(reg1), .reg2(reg2), .byp1(byp1), .byp2(byp2)
  );

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = W'(i);
  endtask

  // Expected read data: PC slot or beyond reads zero, a live write wins, else the stored value.
  function automatic logic [W-1:0] exp_data(input int src);
    if (src >= N) return '0;
    if (!rst && WB_en && int'(WB_dst) == src) return WB_value;
    return model[src];
  endfunction

  function automatic logic exp_byp(input int src);
    return (src < N) && !rst && WB_en && (int'(WB_dst) == src);
  endfunction

  // Advance one clock edge, applying the architectural effect of the presented write.
  task automatic step();
    logic         do_wr;
    int           d;
    logic [W-1:0] v;
    do_wr = !rst && WB_en;
    d     = int'(WB_dst);
    v     = WB_value;
    @(posedge clk);
    if (rst) model_reset();
    else if (do_wr && d < N) model[d] = v;
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] e1, e2;
    for (int k = 0; k < 8; k++) begin
      src1 = A'(2 * k); src2 = A'(2 * k + 1);
      WB_en = 1'b1; WB_dst = src1; WB_value = 32'hA5A5_0000;
      #1;
      e1 = W'(2 * k);
      e2 = (2 * k + 1 < N) ? W'(2 * k + 1) : '0;
      checks++; if (reg1 !== e1) begin errors++; $display("FAIL reset_reg1 src=%0d got %h want %h", src1, reg1, e1); end
      checks++; if (reg2 !== e2) begin errors++; $display("FAIL reset_reg2 src=%0d got %h want %h", src2, reg2, e2); end
      checks++; if ({byp1, byp2} !== 2'b00) begin errors++; $display("FAIL reset_byp got %b want 00", {byp1, byp2}); end
    end
    WB_en = 1'b0;
  endtask

  task automatic test_write_read();
    WB_en = 1'b1; WB_dst = 4'd3; WB_value = 32'hDEAD_BEEF;
    step();
    WB_en = 1'b0; src1 = 4'd3;
    #1;
    checks++; if (reg1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd_reg1 got %h want deadbeef", reg1); end
    checks++; if (byp1 !== 1'b0) begin errors++; $display("FAIL wr_rd_byp1 got %b want 0", byp1); end
  endtask

  task automatic test_bypass();
    src1 = 4'd5; src2 = 4'd5; WB_en = 1'b1; WB_dst = 4'd5; WB_value = 32'h1234;
    #1;
    checks++; if (reg1 !== 32'h1234) begin errors++; $display("FAIL byp_reg1 got %h want 00001234", reg1); end
    checks++; if (reg2 !== 32'h1234) begin errors++; $display("FAIL byp_reg2 got %h want 00001234", reg2); end
    checks++; if ({byp1, byp2} !== 2'b11) begin errors++; $display("FAIL byp_flags got %b want 11", {byp1, byp2}); end
    step();
    WB_en = 1'b0;
    #1;
    checks++; if (reg1 !== 32'h1234 || byp1 !== 1'b0) begin errors++; $display("FAIL byp_after got %h/%b want 00001234/0", reg1, byp1); end
  endtask

  task automatic test_pc_slot();
    WB_en = 1'b1; WB_dst = 4'd15; WB_value = 32'hFFFF_FFFF; src1 = 4'd15; src2 = 4'd15;
    #1;
    checks++; if (reg1 !== '0 || byp1 !== 1'b0) begin errors++; $display("FAIL pc_live got %h/%b want 0/0", reg1, byp1); end
    step();
    WB_en = 1'b0;
    #1;
    checks++; if (reg1 !== '0 || reg2 !== '0 || byp1 !== 1'b0) begin errors++; $display("FAIL pc_after got %h/%h/%b want 0/0/0", reg1, reg2, byp1); end
    for (int i = 0; i < N; i++) begin
      src1 = A'(i);
      #1;
      checks++; if (reg1 !== model[i]) begin errors++; $display("FAIL pc_untouched R%0d got %h want %h", i, reg1, model[i]); end
    end
  endtask

  task automatic test_wb_disabled();
    WB_en = 1'b0; WB_dst = 4'd7; WB_value = 32'd99; src1 = 4'd7;
    #1;
    checks++; if (byp1 !== 1'b0) begin errors++; $display("FAIL wbdis_byp got %b want 0", byp1); end
    step();
    checks++; if (reg1 !== 32'd7 || byp1 !== 1'b0) begin errors++; $display("FAIL wbdis_r7 got %h/%b want 7/0", reg1, byp1); end
  endtask

  task automatic test_back_to_back();
    WB_en = 1'b1; WB_dst = 4'd9; WB_value = 32'hAAAA_0001; src1 = 4'd9; src2 = 4'd9;
    #1;
    checks++; if (reg1 !== 32'hAAAA_0001 || byp1 !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b want aaaa0001/1", reg1, byp1); end
    step();
    WB_value = 32'hBBBB_0002;
    #1;
    checks++; if (reg2 !== 32'hBBBB_0002 || byp2 !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b want bbbb0002/1", reg2, byp2); end
    step();
    src2 = 4'd2; WB_dst = 4'd2; WB_value = 32'hCCCC_0003;
    #1;
    checks++; if (reg1 !== 32'hBBBB_0002 || byp1 !== 1'b0) begin errors++; $display("FAIL b2b_last got %h/%b want bbbb0002/0", reg1, byp1); end
    checks++; if (reg2 !== 32'hCCCC_0003 || byp2 !== 1'b1) begin errors++; $display("FAIL b2b_mixed got %h/%b want cccc0003/1", reg2, byp2); end
    step();
    WB_en = 1'b0;
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    test_reset();
    // Hold reset across an edge with a write presented: storage must stay at its reset values.
    WB_en = 1'b1; WB_dst = 4'd4; WB_value = $urandom;
    step();
    src1 = 4'd4;
    #1;
    checks++; if (reg1 !== 32'd4 || byp1 !== 1'b0) begin errors++; $display("FAIL rst_hold got %h/%b want 4/0", reg1, byp1); end
    @(negedge clk);
    rst = 1'b0; WB_en = 1'b0;
    src1 = 4'd3; src2 = 4'd9;
    #1;
    checks++; if (reg1 !== 32'd3 || reg2 !== 32'd9) begin errors++; $display("FAIL rst_after got %h/%h want 3/9", reg1, reg2); end
  endtask

  task automatic test_random();
    logic [W-1:0] e1, e2;
    logic         b1, b2;
    for (int c = 0; c < 2000; c++) begin
      src1 = A'($urandom_range(0, 15));
      src2 = A'($urandom_range(0, 15));
      WB_en = 1'($urandom_range(0, 1));
      WB_dst = A'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) WB_dst = src1;
      if ($urandom_range(0, 5) == 0) WB_dst = src2;
      WB_value = $urandom;
      #1;
      e1 = exp_data(int'(src1)); e2 = exp_data(int'(src2));
      b1 = exp_byp(int'(src1));  b2 = exp_byp(int'(src2));
      checks++; if (reg1 !== e1) begin errors++; $display("FAIL rnd_reg1 cyc=%0d got %h want %h", c, reg1, e1); end
      checks++; if (reg2 !== e2) begin errors++; $display("FAIL rnd_reg2 cyc=%0d got %h want %h", c, reg2, e2); end
      checks++; if (byp1 !== b1) begin errors++; $display("FAIL rnd_byp1 cyc=%0d got %b want %b", c, byp1, b1); end
      checks++; if (byp2 !== b2) begin errors++; $display("FAIL rnd_byp2 cyc=%0d got %b want %b", c, byp2, b2); end
      step();
    end
    WB_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    src1 = '0; src2 = '0; WB_en = 1'b0; WB_dst = '0; WB_value = '0;
    model_reset();
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    test_write_read();
    test_bypass();
    test_pc_slot();
    test_wb_disabled();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
